ram_upload: RTL and testbench

//  Reader-side counterpart of the HPS ioctl download path: serves byte reads from the HPS
//  (ioctl upload) out of the CPU's 4k work RAM so a running program's RAM can be saved.

---
 rtl/ram_upload.sv | 138 +++++++++++++
 tb/tb_ram_upload.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_upload.sv
// Serves HPS ioctl upload byte reads out of a 2**AW-byte work RAM through a second RAM
// port, holding the CPU in WAIT for the whole session so the saved image is consistent.
module ram_upload #(
    parameter int          AW       = 12,
    parameter int          HOLD_CYC = 4,
    parameter logic [7:0]  FILL     = 8'hFF
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_upload,
    input  logic          ioctl_rd,
    input  logic [26:0]   ioctl_addr,
    output logic [7:0]    ioctl_din,
    output logic [AW-1:0] ram_addr,
    output logic          ram_rd,
    input  logic [7:0]    ram_q,
    output logic          cpu_wait_n,
    output logic          upload_active,
    output logic [15:0]   byte_count,
    output logic          upload_done
);

    localparam int HW = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        READY,
        FETCH,
        CAPTURE
    } state_t;

    state_t        state;
    logic [HW-1:0] hold_cnt;
    logic          pend_valid;
    logic [26:0]   pend_addr;

    logic          req_valid;
    logic [26:0]   req_addr;
    logic          req_in_range;
    logic [15:0]   count_next;

    // A live pulse takes priority over the pending slot; both carry the same session intent.
    assign req_valid    = ioctl_rd | pend_valid;
    assign req_addr     = ioctl_rd ? ioctl_addr : pend_addr;
    assign req_in_range = (req_addr >> AW) == 27'd0;
    assign count_next   = (byte_count == 16'hFFFF) ? byte_count : byte_count + 16'd1;

    // NOTE: every register here is state, so only non-blocking assignments are used;
    // blocking ones would let later statements see this cycle's new values.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            pend_valid    <= 1'b0;
            pend_addr     <= '0;
            ioctl_din     <= 8'h00;
            ram_addr      <= '0;
            ram_rd        <= 1'b0;
            cpu_wait_n    <= 1'b1;
            upload_active <= 1'b0;
            byte_count    <= 16'd0;
            upload_done   <= 1'b0;
        end else begin
            upload_done <= 1'b0;

            case (state)
                IDLE: begin
                    if (ioctl_upload) begin
                        state         <= HOLD;
                        hold_cnt      <= '0;
                        byte_count    <= 16'd0;
                        cpu_wait_n    <= 1'b0;
                        upload_active <= 1'b1;
                        if (ioctl_rd) begin
                            pend_valid <= 1'b1;
                            pend_addr  <= ioctl_addr;
                        end
                    end
                end

                // Give the Z80 time to reach a WAIT-sampling T-state before RAM is read.
                HOLD: begin
                    if (ioctl_rd) begin
                        pend_valid <= 1'b1;
                        pend_addr  <= ioctl_addr;
                    end
                    if (hold_cnt == HW'(HOLD_CYC - 1)) begin
                        state <= READY;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end

                READY: begin
                    if (req_valid) begin
                        pend_valid <= 1'b0;
                        if (req_in_range) begin
                            ram_addr <= req_addr[AW-1:0];
                            ram_rd   <= 1'b1;
                            state    <= FETCH;
                        end else begin
                            ioctl_din  <= FILL;
                            byte_count <= count_next;
                        end
                    end else if (!ioctl_upload) begin
                        state         <= IDLE;
                        cpu_wait_n    <= 1'b1;
                        upload_active <= 1'b0;
                        upload_done   <= 1'b1;
                    end
                end

                FETCH: begin
                    ram_rd <= 1'b0;
                    state  <= CAPTURE;
                    if (ioctl_rd) begin
                        pend_valid <= 1'b1;
                        pend_addr  <= ioctl_addr;
                    end
                end

                CAPTURE: begin
                    ioctl_din  <= ram_q;
                    byte_count <= count_next;
                    state      <= READY;
                    if (ioctl_rd) begin
                        pend_valid <= 1'b1;
                        pend_addr  <= ioctl_addr;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_upload.sv
// Self-checking bench for ram_upload: owns the work RAM (HPS read port plus a CPU writer
// that honours WAIT) and predicts every served byte and count from the RAM contents.
module tb_ram_upload;

    localparam int AW       = 12;
    localparam int HOLD_CYC = 4;
    localparam int DEPTH    = 1 << AW;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic          ioctl_upload = 1'b0;
    logic          ioctl_rd = 1'b0;
    logic [26:0]   ioctl_addr = '0;
    logic [7:0]    ioctl_din;
    logic [AW-1:0] ram_addr;
    logic          ram_rd;
    logic [7:0]    ram_q = 8'h00;
    logic          cpu_wait_n;
    logic          upload_active;
    logic [15:0]   byte_count;
    logic          upload_done;

    int passes = 0;
    int checks = 0;
    int exp_count = 0;

    ram_upload #(.AW(AW), .HOLD_CYC(HOLD_CYC), .FILL(8'hFF)) dut (
        .clk_sys       (clk_sys),
        .reset_n       (reset_n),
        .ioctl_upload  (ioctl_upload),
        .ioctl_rd      (ioctl_rd),
        .ioctl_addr    (ioctl_addr),
        .ioctl_din     (ioctl_din),
        .ram_addr      (ram_addr),
        .ram_rd        (ram_rd),
        .ram_q         (ram_q),
        .cpu_wait_n    (cpu_wait_n),
        .upload_active (upload_active),
        .byte_count    (byte_count),
        .upload_done   (upload_done)
    );

    always #5 clk_sys = ~clk_sys;

    // Work RAM: bench load port, a CPU that writes only while not stalled, and the read port.
    logic [7:0]    mem [0:DEPTH-1];
    logic          tb_we = 1'b0;
    logic [AW-1:0] tb_wa = '0;
    logic [7:0]    tb_wd = 8'h00;
    logic          cpu_run = 1'b0;
    logic [AW-1:0] cpu_ptr = '0;
    int            cpu_writes = 0;

    always @(posedge clk_sys) begin
        if (ram_rd) ram_q <= mem[ram_addr];
        if (tb_we) begin
            mem[tb_wa] <= tb_wd;
        end else if (cpu_run && cpu_wait_n) begin
            mem[cpu_ptr] <= cpu_ptr[7:0] ^ 8'(cpu_writes) ^ 8'h5A;
            cpu_ptr      <= cpu_ptr + 1'b1;
            cpu_writes   <= cpu_writes + 1;
        end
    end

    function automatic logic [7:0] exp_byte(input logic [26:0] a);
        if (a < 27'(DEPTH)) return mem[a[AW-1:0]];
        return 8'hFF;
    endfunction

    function automatic int sat16(input int c);
        return (c > 65535) ? 65535 : c;
    endfunction

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic load_byte(input int a, input logic [7:0] d);
        tb_we = 1'b1; tb_wa = AW'(a); tb_wd = d;
        cyc();
        tb_we = 1'b0;
    endtask

    task automatic load_pattern();
        tb_we = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            tb_wa = AW'(i);
            tb_wd = 8'(i * 7 + 3) ^ 8'(i >> 8);
            cyc();
        end
        tb_we = 1'b0;
    endtask

    // Pulse ioctl_rd for one cycle and sample the outputs 1, 2 and 3 edges later.
    task automatic issue_read(input logic [26:0] a, output logic rd1, output logic [AW-1:0] addr1,
                              output logic [7:0] din1, output logic rd2, output logic [7:0] din3);
        ioctl_addr = a;
        ioctl_rd   = 1'b1;
        cyc();
        rd1 = ram_rd; addr1 = ram_addr; din1 = ioctl_din;
        ioctl_rd = 1'b0;
        cyc();
        rd2 = ram_rd;
        cyc();
        din3 = ioctl_din;
    endtask

    task automatic start_session();
        ioctl_upload = 1'b1;
        exp_count    = 0;
        cyc(HOLD_CYC + 2);
    endtask

    task automatic end_session(output int pulses, output logic wait_after);
        pulses = 0;
        ioctl_upload = 1'b0;
        repeat (20) begin
            cyc();
            if (upload_done === 1'b1) pulses++;
        end
        wait_after = cpu_wait_n;
    endtask

    task automatic test_reset();
        logic rd1, rd2; logic [AW-1:0] a1; logic [7:0] d1, d3;
        logic [44:0] idle_vec;
        idle_vec = {8'h00, 12'h000, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
        reset_n = 1'b0;
        cyc(2);
        checks++;
        if ({ioctl_din, ram_addr, ram_rd, cpu_wait_n, upload_active, byte_count, upload_done} !== idle_vec)
            $display("FAIL reset_initial: outputs=%h want %h",
                     {ioctl_din, ram_addr, ram_rd, cpu_wait_n, upload_active, byte_count, upload_done}, idle_vec);
        else passes++;
        reset_n = 1'b1;
        cyc();
        start_session();
        issue_read(27'h2345, rd1, a1, d1, rd2, d3);
        reset_n = 1'b0;
        cyc(2);
        checks++;
        if ({ioctl_din, ram_addr, ram_rd, cpu_wait_n, upload_active, byte_count, upload_done} !== idle_vec)
            $display("FAIL reset_mid_session: outputs=%h want %h",
                     {ioctl_din, ram_addr, ram_rd, cpu_wait_n, upload_active, byte_count, upload_done}, idle_vec);
        else passes++;
        ioctl_upload = 1'b0;
        reset_n = 1'b1;
        begin
            int pulses = 0;
            repeat (10) begin
                cyc();
                if (upload_done === 1'b1 || upload_active !== 1'b0) pulses++;
            end
            checks++;
            if (pulses != 0) $display("FAIL reset_no_done: got %0d active/done cycles want 0", pulses);
            else passes++;
        end
    endtask

    task automatic test_single_read();
        logic rd1, rd2; logic [AW-1:0] a1; logic [7:0] d1, d3;
        load_byte(12'h010, 8'hA5);
        start_session();
        checks++;
        if (cpu_wait_n !== 1'b0 || upload_active !== 1'b1)
            $display("FAIL session_flags: wait_n=%b active=%b want 0/1", cpu_wait_n, upload_active);
        else passes++;
        issue_read(27'h010, rd1, a1, d1, rd2, d3);
        exp_count++;
        checks++;
        if (rd1 !== 1'b1 || a1 !== 12'h010)
            $display("FAIL single_fetch: ram_rd=%b ram_addr=%h want 1/010", rd1, a1);
        else passes++;
        checks++;
        if (rd2 !== 1'b0) $display("FAIL single_rd_pulse: ram_rd=%b at N+2 want 0", rd2);
        else passes++;
        checks++;
        if (d3 !== 8'hA5 || byte_count !== 16'(exp_count))
            $display("FAIL single_data: din=%h count=%0d want a5/%0d", d3, byte_count, exp_count);
        else passes++;
    endtask

    task automatic test_out_of_range();
        logic rd1, rd2; logic [AW-1:0] a1; logic [7:0] d1, d3;
        int pulses; logic w;
        for (int k = 0; k < 4; k++) begin
            logic [26:0] a;
            a = (k == 0) ? 27'h1000 : 27'($urandom_range(DEPTH, (1 << 27) - 1));
            issue_read(a, rd1, a1, d1, rd2, d3);
            exp_count++;
            checks++;
            if (d1 !== 8'hFF || rd1 !== 1'b0 || byte_count !== 16'(exp_count))
                $display("FAIL oor_%0d: addr=%h din=%h ram_rd=%b count=%0d want ff/0/%0d",
                         k, a, d1, rd1, byte_count, exp_count);
            else passes++;
            cyc(5);
        end
        end_session(pulses, w);
        checks++;
        if (pulses != 1 || w !== 1'b1 || byte_count !== 16'(exp_count))
            $display("FAIL oor_exit: done_pulses=%0d wait_n=%b count=%0d want 1/1/%0d", pulses, w, byte_count, exp_count);
        else passes++;
    endtask

    task automatic test_rd_in_hold();
        int pulses; logic w;
        for (int k = 0; k < 2; k++) begin
            logic [26:0] a;
            bit found;
            a = 27'($urandom_range(0, DEPTH - 1));
            found = 0;
            ioctl_upload = 1'b1;
            ioctl_addr   = a;
            if (k == 0) begin
                cyc();
                ioctl_rd = 1'b1;
            end else begin
                ioctl_rd = 1'b1;
            end
            cyc();
            ioctl_rd = 1'b0;
            for (int t = 0; t < 30; t++) begin
                if (byte_count === 16'd1) begin
                    found = 1;
                    break;
                end
                cyc();
            end
            checks++;
            if (!found || ioctl_din !== exp_byte(a) || cpu_wait_n !== 1'b0)
                $display("FAIL hold_pending_%0d: found=%0d din=%h wait_n=%b want 1/%h/0",
                         k, found, ioctl_din, cpu_wait_n, exp_byte(a));
            else passes++;
            end_session(pulses, w);
        end
    endtask

    task automatic test_random_reads();
        logic rd1, rd2; logic [AW-1:0] a1; logic [7:0] d1, d3;
        int pulses; logic w;
        start_session();
        for (int k = 0; k < 40; k++) begin
            logic [26:0] a;
            a = ($urandom_range(0, 3) == 0) ? 27'($urandom_range(DEPTH, (1 << 27) - 1))
                                            : 27'($urandom_range(0, DEPTH - 1));
            issue_read(a, rd1, a1, d1, rd2, d3);
            exp_count = sat16(exp_count + 1);
            checks++;
            if (d3 !== exp_byte(a) || byte_count !== 16'(exp_count))
                $display("FAIL random_%0d: addr=%h din=%h count=%0d want %h/%0d",
                         k, a, d3, byte_count, exp_byte(a), exp_count);
            else passes++;
            cyc(5);
        end
        end_session(pulses, w);
    endtask

    task automatic test_back_to_back();
        logic [26:0] a1, a2;
        logic [7:0] first;
        int pulses; logic w;
        start_session();
        a1 = 27'($urandom_range(0, DEPTH - 1));
        a2 = 27'($urandom_range(0, DEPTH - 1));
        ioctl_addr = a1; ioctl_rd = 1'b1;
        cyc();
        ioctl_addr = a2;
        cyc();
        ioctl_rd = 1'b0;
        cyc();
        first = ioctl_din;
        cyc(8);
        exp_count += 2;
        checks++;
        if (first !== exp_byte(a1) || ioctl_din !== exp_byte(a2) || byte_count !== 16'(exp_count))
            $display("FAIL back_to_back: first=%h last=%h count=%0d want %h/%h/%0d",
                     first, ioctl_din, byte_count, exp_byte(a1), exp_byte(a2), exp_count);
        else passes++;
        // Upload drops while a fetch is in flight: the byte still completes before exit.
        a1 = 27'($urandom_range(0, DEPTH - 1));
        ioctl_addr = a1; ioctl_rd = 1'b1;
        cyc();
        ioctl_rd = 1'b0;
        end_session(pulses, w);
        exp_count++;
        checks++;
        if (pulses != 1 || w !== 1'b1 || ioctl_din !== exp_byte(a1) || byte_count !== 16'(exp_count))
            $display("FAIL fall_in_fetch: pulses=%0d wait_n=%b din=%h count=%0d want 1/1/%h/%0d",
                     pulses, w, ioctl_din, byte_count, exp_byte(a1), exp_count);
        else passes++;
    endtask

    task automatic test_sequential();
        logic rd1, rd2; logic [AW-1:0] a1; logic [7:0] d1, d3;
        int errs, pulses, width;
        logic wait_at_done;
        errs = 0; pulses = 0; width = 0; wait_at_done = 1'b0;
        start_session();
        for (int i = 0; i < DEPTH; i++) begin
            issue_read(27'(i), rd1, a1, d1, rd2, d3);
            if (d3 !== exp_byte(27'(i))) errs++;
            cyc(5);
        end
        checks++;
        if (errs != 0) $display("FAIL seq_data: %0d bad bytes want 0", errs);
        else passes++;
        checks++;
        if (byte_count !== 16'(DEPTH)) $display("FAIL seq_count: count=%0d want %0d", byte_count, DEPTH);
        else passes++;
        ioctl_upload = 1'b0;
        repeat (20) begin
            cyc();
            if (upload_done === 1'b1) begin
                if (pulses == 0) wait_at_done = cpu_wait_n;
                pulses++;
            end
        end
        checks++;
        if (pulses != 1 || wait_at_done !== 1'b1 || byte_count !== 16'(DEPTH))
            $display("FAIL seq_done: pulses=%0d wait_n=%b count=%0d want 1/1/%0d",
                     pulses, wait_at_done, byte_count, DEPTH);
        else passes++;
    endtask

    task automatic test_cpu_stall();
        logic rd1, rd2; logic [AW-1:0] a1; logic [7:0] d1, d3;
        int w0, viol, pulses;
        longint cs_ref, cs_up;
        logic w;
        viol = 0; cs_ref = 0; cs_up = 0;
        cpu_run = 1'b1;
        cyc(50);
        ioctl_upload = 1'b1;
        cyc();
        w0 = cpu_writes;
        for (int i = 0; i < DEPTH; i++) cs_ref += longint'(mem[i]) * (i + 1);
        cyc(HOLD_CYC + 1);
        for (int i = 0; i < DEPTH; i++) begin
            issue_read(27'(i), rd1, a1, d1, rd2, d3);
            cs_up += longint'(d3) * (i + 1);
            if (cpu_wait_n !== 1'b0) viol++;
            cyc();
        end
        checks++;
        if (viol != 0 || cpu_writes != w0)
            $display("FAIL cpu_stall: wait_violations=%0d writes=%0d want 0/%0d", viol, cpu_writes, w0);
        else passes++;
        checks++;
        if (cs_up != cs_ref) $display("FAIL image_checksum: got %0d want %0d", cs_up, cs_ref);
        else passes++;
        end_session(pulses, w);
        checks++;
        if (pulses != 1 || cpu_writes <= w0)
            $display("FAIL cpu_resume: pulses=%0d writes=%0d want 1/>%0d", pulses, cpu_writes, w0);
        else passes++;
        cpu_run = 1'b0;
    endtask

    initial begin
        test_reset();
        load_pattern();
        test_single_read();
        test_out_of_range();
        test_rd_in_hold();
        test_random_reads();
        test_back_to_back();
        test_sequential();
        test_cpu_stall();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
